// File: rtl/universal_shift_reg_pkg.sv
// Shared encodings for the universal shift register: mode select values and
// the burst FSM states.
package universal_shift_reg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic is_shift(mode_e m);
        return (m == MODE_SHR) || (m == MODE_SHL);
    endfunction

endpackage

// File: rtl/universal_shift_reg_if.sv
// Control/data bundle of the universal shift register; the master side drives
// the mode, serial and burst inputs, the slave side (the register) drives Q.
interface universal_shift_reg_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);
    logic [1:0]       S;
    logic             SIR;
    logic             SIL;
    logic [WIDTH-1:0] I;
    logic             run;
    logic [CNT_W-1:0] len;
    logic [WIDTH-1:0] Q;
    logic             SOR;
    logic             SOL;
    logic             busy;
    logic             done;

    modport master (
        output S, SIR, SIL, I, run, len,
        input  Q, SOR, SOL, busy, done
    );

    modport slave (
        input  S, SIR, SIL, I, run, len,
        output Q, SOR, SOL, busy, done
    );
endinterface

// File: rtl/universal_shift_reg_cell.sv
// One register bit: 4:1 next-value mux (hold / shift-right source /
// shift-left source / parallel bit) into a flop with synchronous active-low clear.
module usr_cell
    import universal_shift_reg_pkg::*;
(
    input  logic  clk,
    input  logic  clr,
    input  mode_e mode,
    input  logic  shr_in,
    input  logic  shl_in,
    input  logic  load_in,
    output logic  q
);

    logic q_q, q_d;

    always_comb begin
        q_d = q_q;
        case (mode)
            MODE_HOLD: q_d = q_q;
            MODE_SHR:  q_d = shr_in;
            MODE_SHL:  q_d = shl_in;
            MODE_LOAD: q_d = load_in;
            default:   q_d = q_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) q_q <= 1'b0;
        else      q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register with an automatic multi-shift burst; the FSM and
// run-length counter pick one effective mode that drives every bit cell.
module universal_shift_reg
    import universal_shift_reg_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                  Clk,
    input  logic                  clr,
    universal_shift_reg_if.slave  bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mode_e            dir_q, dir_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    mode_e            mode_s;
    mode_e            eff_mode;
    logic [WIDTH-1:0] q;

    always_comb begin
        mode_s   = mode_e'(bus.S);
        state_d  = state_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        done_d   = 1'b0;
        eff_mode = MODE_HOLD;
        case (state_q)
            ST_IDLE: begin
                // A burst is only accepted for a shift mode with a nonzero
                // length; Q holds on the accepting edge.
                if (bus.run && (bus.len != '0) && is_shift(mode_s)) begin
                    state_d = ST_RUN;
                    cnt_d   = bus.len;
                    dir_d   = mode_s;
                end else begin
                    eff_mode = mode_s;
                end
            end
            ST_RUN: begin
                eff_mode = dir_q;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clk) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dir_q   <= MODE_HOLD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Bit i takes bit i+1 on a right shift and bit i-1 on a left shift;
    // the end bits take the serial inputs instead.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic shr_src, shl_src;
        if (i == WIDTH - 1) begin : g_msb
            assign shr_src = bus.SIR;
        end else begin : g_mid_r
            assign shr_src = q[i+1];
        end
        if (i == 0) begin : g_lsb
            assign shl_src = bus.SIL;
        end else begin : g_mid_l
            assign shl_src = q[i-1];
        end
        usr_cell u_cell (
            .clk     (Clk),
            .clr     (clr),
            .mode    (eff_mode),
            .shr_in  (shr_src),
            .shl_in  (shl_src),
            .load_in (bus.I[i]),
            .q       (q[i])
        );
    end

    assign bus.Q    = q;
    assign bus.SOR  = q[0];
    assign bus.SOL  = q[WIDTH-1];
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Randomized and directed bench for universal_shift_reg (WIDTH=4) against a
// cycle-level behavioural model.
module tb_universal_shift_reg;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic Clk = 1'b0;
    logic clr;
    int   total = 0;
    int   bad   = 0;

    universal_shift_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    universal_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .Clk (Clk),
        .clr (clr),
        .bus (bus.slave)
    );

    always #5 Clk = ~Clk;

    // Model: register value, shifts still owed, burst direction, done phase.
    logic [WIDTH-1:0] m_q;
    int               m_rem;
    logic [1:0]       m_dir;
    bit               m_done;

    function automatic logic [WIDTH-1:0] shift(logic [WIDTH-1:0] v, logic [1:0] d,
                                               logic sir, logic sil);
        if (d == 2'b01) return (v >> 1) | (WIDTH'(sir) << (WIDTH - 1));
        return (v << 1) | WIDTH'(sil);
    endfunction

    task automatic tick();
        @(posedge Clk);
        if (!clr) begin
            m_q = '0; m_rem = 0; m_done = 0;
        end else if (m_rem > 0) begin
            m_q = shift(m_q, m_dir, bus.SIR, bus.SIL);
            m_rem--;
            m_done = (m_rem == 0);
        end else if (m_done) begin
            m_done = 0;
        end else if (bus.run && bus.len != 0 && (bus.S == 2'b01 || bus.S == 2'b10)) begin
            m_rem = int'(bus.len);
            m_dir = bus.S;
        end else if (bus.S == 2'b01 || bus.S == 2'b10) begin
            m_q = shift(m_q, bus.S, bus.SIR, bus.SIL);
        end else if (bus.S == 2'b11) begin
            m_q = bus.I;
        end
        #1;
    endtask

    task automatic set_in(logic [1:0] s, logic sir, logic sil, logic [WIDTH-1:0] i,
                          logic r, logic [CNT_W-1:0] l);
        bus.S = s; bus.SIR = sir; bus.SIL = sil; bus.I = i; bus.run = r; bus.len = l;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        set_in(2'b11, 1'b1, 1'b1, 4'b1111, 1'b0, 3'd0);
        tick();
        set_in(2'b01, 1'b1, 1'b0, 4'b0000, 1'b1, 3'd5);
        tick();
        tick();
        clr = 1'b0;
        tick();
        total++; if (bus.Q !== 4'b0000) begin bad++; $display("FAIL reset_q got=%b exp=0000", bus.Q); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        clr = 1'b1;
    endtask

    task automatic test_load_hold();
        set_in(2'b11, 1'b0, 1'b0, 4'b1011, 1'b0, 3'd0);
        tick();
        total++; if (bus.Q !== 4'b1011) begin bad++; $display("FAIL load_q got=%b exp=1011", bus.Q); end
        set_in(2'b00, 1'b1, 1'b0, 4'b0000, 1'b0, 3'd0);
        for (int k = 0; k < 3; k++) tick();
        total++; if (bus.Q !== 4'b1011) begin bad++; $display("FAIL hold_q got=%b exp=1011", bus.Q); end
        total++; if (bus.SOR !== 1'b1) begin bad++; $display("FAIL hold_sor got=%b exp=1", bus.SOR); end
        total++; if (bus.SOL !== 1'b1) begin bad++; $display("FAIL hold_sol got=%b exp=1", bus.SOL); end
    endtask

    task automatic test_shift();
        set_in(2'b01, 1'b1, 1'b0, 4'b0000, 1'b0, 3'd0);
        tick();
        total++; if (bus.Q !== 4'b1101) begin bad++; $display("FAIL shr1_q got=%b exp=1101", bus.Q); end
        bus.SIR = 1'b0;
        tick();
        total++; if (bus.Q !== 4'b0110) begin bad++; $display("FAIL shr0_q got=%b exp=0110", bus.Q); end
        set_in(2'b10, 1'b0, 1'b1, 4'b0000, 1'b0, 3'd0);
        tick();
        total++; if (bus.Q !== 4'b1101) begin bad++; $display("FAIL shl1_q got=%b exp=1101", bus.Q); end
        total++; if (bus.SOL !== 1'b1 || bus.SOR !== 1'b1) begin
            bad++; $display("FAIL shl_serial_out got=%b%b exp=11", bus.SOL, bus.SOR); end
    endtask

    task automatic test_burst();
        logic [WIDTH-1:0] exp_seq [3];
        exp_seq[0] = 4'b0100; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0001;
        set_in(2'b11, 1'b0, 1'b0, 4'b1001, 1'b0, 3'd0);
        tick();
        set_in(2'b01, 1'b0, 1'b0, 4'b0000, 1'b1, 3'd3);
        tick();
        total++; if (bus.Q !== 4'b1001 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL burst_accept q=%b busy=%b exp q=1001 busy=1", bus.Q, bus.busy); end
        set_in(2'b11, 1'b0, 1'b0, 4'b1111, 1'b0, 3'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (bus.Q !== exp_seq[k]) begin
                bad++; $display("FAIL burst_q%0d got=%b exp=%b", k, bus.Q, exp_seq[k]); end
            total++; if (bus.done !== (k == 2) || bus.busy !== 1'b1) begin
                bad++; $display("FAIL burst_flags%0d done=%b busy=%b", k, bus.done, bus.busy); end
        end
        tick();
        total++; if (bus.Q !== 4'b0001 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++; $display("FAIL burst_end q=%b busy=%b done=%b exp 0001/0/0", bus.Q, bus.busy, bus.done); end
        bus.S = 2'b00;
        tick();
        total++; if (bus.Q !== 4'b0001) begin bad++; $display("FAIL burst_after_q got=%b exp=0001", bus.Q); end
    endtask

    task automatic test_reset_midburst();
        int done_seen = 0;
        set_in(2'b11, 1'b0, 1'b0, 4'b1110, 1'b0, 3'd0);
        tick();
        set_in(2'b10, 1'b0, 1'b1, 4'b0000, 1'b1, 3'd3);
        tick();
        bus.run = 1'b0;
        tick();
        clr = 1'b0;
        tick();
        clr = 1'b1;
        total++; if (bus.Q !== 4'b0000 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL abort_state q=%b busy=%b exp 0000/0", bus.Q, bus.busy); end
        bus.S = 2'b00;
        for (int k = 0; k < 4; k++) begin
            if (bus.done === 1'b1) done_seen++;
            tick();
        end
        total++; if (done_seen != 0 || bus.Q !== 4'b0000) begin
            bad++; $display("FAIL abort_no_done pulses=%0d q=%b exp 0/0000", done_seen, bus.Q); end
    endtask

    task automatic test_ignored_run();
        clr = 1'b0; tick(); clr = 1'b1;
        set_in(2'b01, 1'b1, 1'b0, 4'b0000, 1'b1, 3'd0);
        tick();
        total++; if (bus.Q !== 4'b1000 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL run_len0 q=%b busy=%b exp 1000/0", bus.Q, bus.busy); end
        set_in(2'b11, 1'b0, 1'b0, 4'b0110, 1'b1, 3'd2);
        tick();
        total++; if (bus.Q !== 4'b0110 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++; $display("FAIL run_load q=%b busy=%b done=%b exp 0110/0/0", bus.Q, bus.busy, bus.done); end
    endtask

    task automatic test_max_len();
        int pulses = 0;
        set_in(2'b11, 1'b0, 1'b0, 4'(($urandom)), 1'b0, 3'd0);
        tick();
        set_in(2'b10, 1'b0, 1'b0, 4'b0000, 1'b1, 3'd7);
        tick();
        for (int k = 0; k < 9; k++) begin
            bus.run = 1'($urandom); bus.SIL = 1'($urandom); bus.S = 2'($urandom);
            bus.len = 3'($urandom); bus.I = 4'($urandom);
            tick();
            if (bus.done === 1'b1) pulses++;
            total++; if (bus.Q !== m_q || bus.busy !== ((m_rem > 0) || m_done)) begin
                bad++; $display("FAIL maxlen_c%0d q=%b busy=%b exp q=%b", k, bus.Q, bus.busy, m_q); end
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL maxlen_done_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            clr = ($urandom_range(0, 39) != 0);
            bus.S = 2'($urandom); bus.SIR = 1'($urandom); bus.SIL = 1'($urandom);
            bus.I = 4'($urandom); bus.run = ($urandom_range(0, 2) == 0);
            bus.len = 3'($urandom);
            tick();
            total++; if (bus.Q !== m_q || bus.SOR !== m_q[0] || bus.SOL !== m_q[WIDTH-1]) begin
                bad++; $display("FAIL rand_q c%0d got=%b sor=%b sol=%b exp=%b", k, bus.Q, bus.SOR, bus.SOL, m_q); end
            total++; if (bus.busy !== ((m_rem > 0) || m_done) || bus.done !== m_done) begin
                bad++; $display("FAIL rand_flags c%0d busy=%b done=%b exp busy=%b done=%b",
                                k, bus.busy, bus.done, (m_rem > 0) || m_done, m_done); end
        end
        clr = 1'b1;
    endtask

    initial begin
        m_q = '0; m_rem = 0; m_dir = 2'b01; m_done = 0;
        clr = 1'b0;
        set_in(2'b00, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0);
        #1;
        test_reset();
        test_load_hold();
        test_shift();
        test_burst();
        test_reset_midburst();
        test_ignored_run();
        test_max_len();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
